// File: rtl/pow2_pkg.sv
// Shared definitions for the power-of-two reconstruction block.
//   pow2_state_e : controller states (IDLE, SHIFT, DONE)
//   W_DEF/NW_DEF : default data width and shift-amount width
package pow2_pkg;

  localparam int W_DEF  = 16;
  localparam int NW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } pow2_state_e;

endpackage : pow2_pkg

// File: rtl/low_mask.sv
// Thermometer mask generator: mask = (1 << k) - 1, i.e. bits [k-1:0] set.
// Thermometer counterpart of a one-hot decoder; k = 0 yields all zeros.
// Ports:
//   k    : input  [NW-1:0] number of low bits to set
//   mask : output [W-1:0]  thermometer mask
module low_mask
  import pow2_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int NW = NW_DEF
) (
  input  logic [NW-1:0] k,
  output logic [W-1:0]  mask
);

  logic [31:0] k_ext;

  assign k_ext = 32'(k);

  always_comb begin
    mask = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (32'(i) < k_ext);
    end
  end

endmodule : low_mask

// File: rtl/pow2_reconstruct.sv
// Sequential reconstruction m = (q << n) | (r & ((1<<n)-1)), one shift per clock.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the producer holds its data stable until that edge, and valid never
// depends combinationally on ready in this block.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   q, n, r             : quotient, shift amount (0..W-1), remainder
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   m                   : reconstructed value (registered)
//   ovf                 : a 1-bit was shifted out of bit W-1 (registered)
//   rem_err             : r had set bits at positions >= n (registered)
module pow2_reconstruct
  import pow2_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  q,
  input  logic [NW-1:0] n,
  input  logic [W-1:0]  r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  m,
  output logic          ovf,
  output logic          rem_err
);

  pow2_state_e   state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  r_q, r_d;
  logic [NW-1:0] n_q, n_d;
  logic          ovf_acc_q, ovf_acc_d;
  logic [W-1:0]  m_q, m_d;
  logic          ovf_q, ovf_d;
  logic          rem_err_q, rem_err_d;
  logic [W-1:0]  rem_mask;

  low_mask #(
    .W  (W),
    .NW (NW)
  ) u_low_mask (
    .k    (n_q),
    .mask (rem_mask)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign m         = m_q;
  assign ovf       = ovf_q;
  assign rem_err   = rem_err_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    n_d       = n_q;
    ovf_acc_d = ovf_acc_q;
    m_d       = m_q;
    ovf_d     = ovf_q;
    rem_err_d = rem_err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d     = q;
          cnt_d     = n;
          r_d       = r;
          n_d       = n;
          ovf_acc_d = 1'b0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          ovf_acc_d = ovf_acc_q | acc_q[W-1];
          acc_d     = {acc_q[W-2:0], 1'b0};
          cnt_d     = cnt_q - NW'(1);
        end else begin
          // Low n bits of acc are zero after shifting, so the OR is disjoint.
          m_d       = acc_q | (r_q & rem_mask);
          rem_err_d = |(r_q & ~rem_mask);
          // Overflow is published only at completion so the visible flag
          // stays with the result it describes while the next op runs.
          ovf_d     = ovf_acc_q;
          state_d   = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      r_q       <= '0;
      n_q       <= '0;
      ovf_acc_q <= 1'b0;
      m_q       <= '0;
      ovf_q     <= 1'b0;
      rem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      n_q       <= n_d;
      ovf_acc_q <= ovf_acc_d;
      m_q       <= m_d;
      ovf_q     <= ovf_d;
      rem_err_q <= rem_err_d;
    end
  end

endmodule : pow2_reconstruct

// File: tb/tb_pow2_reconstruct.sv
// Self-checking bench for pow2_reconstruct: directed cases, backpressure,
// asynchronous reset mid-operation and randomized operations against an
// arithmetic reference model.
module tb_pow2_reconstruct;

  localparam int W  = 16;
  localparam int NW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  q;
  logic [NW-1:0] n;
  logic [W-1:0]  r;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  m;
  logic          ovf;
  logic          rem_err;

  int total;
  int bad;

  pow2_reconstruct #(.W(W), .NW(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .n         (n),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m         (m),
    .ovf       (ovf),
    .rem_err   (rem_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on a wide value.
  task automatic model(input logic [W-1:0] qi, input int ni, input logic [W-1:0] ri,
                       output logic [W-1:0] em, output logic eo, output logic er);
    logic [31:0] full;
    logic [31:0] msk;
    full = {16'h0, qi} << ni;
    msk  = (32'h1 << ni) - 32'h1;
    em   = full[15:0] | (ri & msk[15:0]);
    eo   = (full[31:16] != 16'h0);
    er   = ((32'(ri) >> ni) != 32'h0);
  endtask

  // One complete operation: accept, measure latency, apply hold cycles of
  // backpressure (optionally with a stray in_valid pulse), then release.
  task automatic run_op(input logic [W-1:0] qi, input int ni, input logic [W-1:0] ri,
                        input int hold, input bit stray);
    logic [W-1:0] em;
    logic eo, er;
    int cyc;
    model(qi, ni, ri, em, eo, er);

    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    q = qi;
    n = NW'(ni);
    r = ri;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q = $urandom();
    r = $urandom();
    check("out_valid_after_accept", 32'(out_valid), 32'd0);

    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(ni + 1));
    check("m", 32'(m), 32'(em));
    check("ovf", 32'(ovf), 32'(eo));
    check("rem_err", 32'(rem_err), 32'(er));
    check("in_ready_in_done", 32'(in_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (stray && h == 1) begin
        in_valid = 1'b1;
        q = 16'hFFFF;
        n = 4'd7;
        r = 16'hFFFF;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_m", 32'(m), 32'(em));
      check("hold_ovf", 32'(ovf), 32'(eo));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    check("out_valid_after_release", 32'(out_valid), 32'd0);
    check("m_kept_after_release", 32'(m), 32'(em));
    check("rem_err_kept_after_release", 32'(rem_err), 32'(er));
  endtask

  initial begin
    total = 0;
    bad = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    q = '0;
    n = '0;
    r = '0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_m", 32'(m), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_rem_err", 32'(rem_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(16'h0012, 4, 16'h0007, 0, 1'b0);
    run_op(16'hABCD, 0, 16'hFFFF, 0, 1'b0);
    run_op(16'h8001, 1, 16'h0001, 0, 1'b0);
    run_op(16'h0001, 15, 16'h7FFF, 0, 1'b0);
    run_op(16'hFFFF, 15, 16'hFFFF, 1, 1'b0);

    // Backpressure with a stray in_valid pulse that must be ignored
    run_op(16'h0003, 2, 16'h0001, 4, 1'b1);

    // Reset in the middle of a long shift, without a clock edge
    @(negedge clk);
    in_valid = 1'b1;
    q = 16'hF0F0;
    n = 4'd10;
    r = 16'h03FF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_m", 32'(m), 32'd0);
    check("midreset_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0001, 3, 16'h0005, 0, 1'b0);

    // Randomized operations
    for (int t = 0; t < 25; t++) begin
      run_op(16'($urandom()), int'($urandom_range(0, 15)), 16'($urandom()),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pow2_reconstruct
